// File: rtl/prog_mem_loader.sv
// prog_mem_loader: initiator on the program-memory port, driven from a byte stream.
// Load mode packs incoming bytes big-endian into words written from address 0 upward.
// Dump mode reads words from address 0 upward and sends each one out MSB byte first.
module prog_mem_loader #(
   parameter int          DEPTH     = 32,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_START,
   input  logic        I_DUMP,
   input  logic [7:0]  I_RX_BYTE,
   input  logic        I_RX_VALID,
   output logic        O_RX_READY,
   output logic [7:0]  O_TX_BYTE,
   output logic        O_TX_VALID,
   input  logic        I_TX_READY,
   output logic        O_MEMREAD,
   output logic        O_MEMWRITE,
   output logic [31:0] O_ADDR,
   output logic [31:0] O_WRITE_DATA,
   input  logic [31:0] I_READ_DATA,
   output logic        O_BUSY,
   output logic        O_DONE,
   output logic [5:0]  O_WORD_COUNT
);

   localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, RX, WR, RD, RDW, TX, FIN} state_t;

   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic [AW:0]   count_q;
   logic [1:0]    idx_q;
   logic [31:0]   shift_q;
   logic [31:0]   wdata_q;
   logic [7:0]    tx_byte_q;
   logic          rx_ready_q;
   logic          tx_valid_q;
   logic          memread_q;
   logic          memwrite_q;
   logic          done_q;
   logic [31:0]   shift_d;

   // Incoming byte lands in the low lane so the first byte ends up in [31:24].
   assign shift_d = {shift_q[23:0], I_RX_BYTE};

   // Sequencer: all strobes and handshakes are registered and set on entry to their state.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         wdata_q    <= '0;
         tx_byte_q  <= '0;
         rx_ready_q <= 1'b0;
         tx_valid_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Load takes priority over dump when both are requested together.
               if (I_START) begin
                  state_q    <= RX;
                  rx_ready_q <= 1'b1;
                  addr_q     <= '0;
                  count_q    <= '0;
                  idx_q      <= '0;
               end else if (I_DUMP) begin
                  state_q   <= RD;
                  memread_q <= 1'b1;
                  addr_q    <= '0;
                  count_q   <= '0;
               end
            end
            RX: begin
               // rx_ready_q is high for the whole RX state, so valid alone means a transfer.
               if (I_RX_VALID) begin
                  shift_q <= shift_d;
                  idx_q   <= idx_q + 1'b1;
                  if (idx_q == 2'd3) begin
                     wdata_q    <= shift_d;
                     rx_ready_q <= 1'b0;
                     memwrite_q <= 1'b1;
                     state_q    <= WR;
                  end
               end
            end
            WR: begin
               memwrite_q <= 1'b0;
               count_q    <= count_q + 1'b1;
               if (wdata_q == HALT_WORD || addr_q == LAST_ADDR) begin
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end else begin
                  addr_q     <= addr_q + 1'b1;
                  idx_q      <= '0;
                  rx_ready_q <= 1'b1;
                  state_q    <= RX;
               end
            end
            RD: begin
               memread_q <= 1'b0;
               state_q   <= RDW;
            end
            RDW: begin
               // Memory registered the word on the strobe edge; it is valid now.
               shift_q    <= I_READ_DATA;
               tx_byte_q  <= I_READ_DATA[31:24];
               tx_valid_q <= 1'b1;
               idx_q      <= '0;
               state_q    <= TX;
            end
            TX: begin
               if (tx_valid_q) begin
                  if (I_TX_READY) begin
                     tx_valid_q <= 1'b0;
                     shift_q    <= {shift_q[23:0], 8'h00};
                     idx_q      <= idx_q + 1'b1;
                     if (idx_q == 2'd3) begin
                        count_q <= count_q + 1'b1;
                        if (addr_q == LAST_ADDR) begin
                           done_q  <= 1'b1;
                           state_q <= FIN;
                        end else begin
                           addr_q    <= addr_q + 1'b1;
                           memread_q <= 1'b1;
                           state_q   <= RD;
                        end
                     end
                  end
               end else begin
                  // Gap cycle after an acceptance: present the next byte.
                  tx_valid_q <= 1'b1;
                  tx_byte_q  <= shift_q[31:24];
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign O_RX_READY   = rx_ready_q;
   assign O_TX_BYTE    = tx_byte_q;
   assign O_TX_VALID   = tx_valid_q;
   assign O_MEMREAD    = memread_q;
   assign O_MEMWRITE   = memwrite_q;
   assign O_ADDR       = 32'(addr_q);
   assign O_WRITE_DATA = wdata_q;
   assign O_BUSY       = (state_q != IDLE);
   assign O_DONE       = done_q;
   assign O_WORD_COUNT = 6'(count_q);

endmodule

// File: tb/tb_prog_mem_loader.sv
// Testbench for prog_mem_loader: behavioural memory, randomized byte-stream
// stalls, and a word-level reference model of load and dump.
`timescale 1ns/1ps
module tb_prog_mem_loader;

   localparam int          DEPTH = 32;
   localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        I_START, I_DUMP;
   logic [7:0]  I_RX_BYTE;
   logic        I_RX_VALID;
   logic        O_RX_READY;
   logic [7:0]  O_TX_BYTE;
   logic        O_TX_VALID;
   logic        I_TX_READY;
   logic        O_MEMREAD, O_MEMWRITE;
   logic [31:0] O_ADDR, O_WRITE_DATA;
   logic [31:0] I_READ_DATA = '0;
   logic        O_BUSY, O_DONE;
   logic [5:0]  O_WORD_COUNT;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   prog_mem_loader #(.DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_START(I_START), .I_DUMP(I_DUMP),
      .I_RX_BYTE(I_RX_BYTE), .I_RX_VALID(I_RX_VALID), .O_RX_READY(O_RX_READY),
      .O_TX_BYTE(O_TX_BYTE), .O_TX_VALID(O_TX_VALID), .I_TX_READY(I_TX_READY),
      .O_MEMREAD(O_MEMREAD), .O_MEMWRITE(O_MEMWRITE),
      .O_ADDR(O_ADDR), .O_WRITE_DATA(O_WRITE_DATA), .I_READ_DATA(I_READ_DATA),
      .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_WORD_COUNT(O_WORD_COUNT)
   );

   // Memory and transfer logs, written only by the clocked model below.
   logic [31:0] mem [DEPTH];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   logic [7:0]  tx_log[$];
   int          n_reads = 0;
   logic        hold_pend = 1'b0;
   logic [7:0]  hold_byte = '0;

   // Program memory model with registered read, plus transfer logging.
   always @(posedge CLK) begin
      if (O_MEMWRITE) begin
         mem[O_ADDR[4:0]] = O_WRITE_DATA;
         wr_addr_log.push_back(O_ADDR);
         wr_data_log.push_back(O_WRITE_DATA);
      end
      if (O_MEMREAD) begin
         I_READ_DATA <= mem[O_ADDR[4:0]];
         n_reads++;
      end
      if (O_TX_VALID && I_TX_READY) tx_log.push_back(O_TX_BYTE);
      hold_pend <= O_TX_VALID && !I_TX_READY && !RESET;
      hold_byte <= O_TX_BYTE;
   end

   logic prev_rd = 1'b0, prev_wr = 1'b0, prev_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and run the protocol checks there.
   task automatic tick();
      @(negedge CLK);
      if (!RESET) begin
         if (O_MEMREAD || O_MEMWRITE) chk("strobe_excl", 32'(O_MEMREAD & O_MEMWRITE), 0);
         if (prev_rd)   chk("memread_width", 32'(O_MEMREAD), 0);
         if (prev_wr)   chk("memwrite_width", 32'(O_MEMWRITE), 0);
         if (prev_done) chk("done_width", 32'(O_DONE), 0);
         if (hold_pend) begin
            chk("tx_hold_valid", 32'(O_TX_VALID), 1);
            chk("tx_hold_byte", 32'(O_TX_BYTE), 32'(hold_byte));
         end
      end
      prev_rd   = O_MEMREAD;
      prev_wr   = O_MEMWRITE;
      prev_done = O_DONE;
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"},   32'(O_BUSY), 0);
      chk({tag, "_rxrdy"},  32'(O_RX_READY), 0);
      chk({tag, "_txval"},  32'(O_TX_VALID), 0);
      chk({tag, "_txbyte"}, 32'(O_TX_BYTE), 0);
      chk({tag, "_rd"},     32'(O_MEMREAD), 0);
      chk({tag, "_wr"},     32'(O_MEMWRITE), 0);
      chk({tag, "_addr"},   O_ADDR, 0);
      chk({tag, "_wdata"},  O_WRITE_DATA, 0);
      chk({tag, "_done"},   32'(O_DONE), 0);
      chk({tag, "_count"},  32'(O_WORD_COUNT), 0);
   endtask

   // Reference: bytes group into big-endian words; stop after HALT or DEPTH words.
   task automatic load_model(input logic [7:0] b[$], output logic [31:0] words[$]);
      words = {};
      for (int w = 0; w < DEPTH && 4 * w + 3 < b.size(); w++) begin
         logic [31:0] v;
         v = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
         words.push_back(v);
         if (v == HALT) break;
      end
   endtask

   task automatic push_word(inout logic [7:0] b[$], input logic [31:0] v);
      for (int j = 3; j >= 0; j--) b.push_back(8'((v >> (8 * j)) & 32'hFF));
   endtask

   task automatic pulse_start();
      tick(); I_START = 1'b1;
      tick(); I_START = 1'b0;
   endtask

   task automatic pulse_dump();
      tick(); I_DUMP = 1'b1;
      tick(); I_DUMP = 1'b0;
   endtask

   // Offer bytes with random valid gaps; keeps offering a few cycles after DONE.
   task automatic feed(input logic [7:0] b[$], input int budget, input bit stop_empty,
                       output int acc, output bit done_seen);
      int i = 0;
      int post = 0;
      acc = 0;
      done_seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (O_DONE) done_seen = 1'b1;
         if (done_seen) post++;
         if (post > 8) break;
         if (stop_empty && i >= b.size()) break;
         if (i < b.size()) begin
            I_RX_BYTE  = b[i];
            I_RX_VALID = ($urandom_range(0, 3) != 0);
         end else begin
            I_RX_VALID = 1'b0;
         end
         if (I_RX_VALID && O_RX_READY) begin
            i++;
            acc++;
         end
      end
      I_RX_VALID = 1'b0;
   endtask

   // Consume TX bytes with random ready stalls until DONE (or budget expiry).
   task automatic drain(input int budget, output bit done_seen);
      int post = 0;
      done_seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (O_DONE) done_seen = 1'b1;
         if (done_seen) post++;
         if (post > 4) break;
         I_TX_READY = ($urandom_range(0, 2) != 0);
      end
      I_TX_READY = 1'b0;
   endtask

   task automatic check_load(input string tag, input logic [31:0] words[$], input int wbase,
                             input int acc, input bit done_seen);
      int n;
      n = wr_data_log.size() - wbase;
      chk({tag, "_done"},    32'(done_seen), 1);
      chk({tag, "_nwrites"}, n, words.size());
      chk({tag, "_rx_acc"},  acc, 4 * words.size());
      for (int k = 0; k < words.size() && k < n; k++) begin
         chk($sformatf("%s_addr%0d", tag, k), wr_addr_log[wbase + k], k);
         chk($sformatf("%s_data%0d", tag, k), wr_data_log[wbase + k], words[k]);
      end
      chk({tag, "_count"}, 32'(O_WORD_COUNT), words.size());
      chk({tag, "_busy"},  32'(O_BUSY), 0);
   endtask

   task automatic check_dump(input string tag, input logic [31:0] words[$], input int tbase,
                             input int rbase, input bit done_seen);
      int n;
      n = tx_log.size() - tbase;
      chk({tag, "_done"},   32'(done_seen), 1);
      chk({tag, "_nbytes"}, n, 4 * DEPTH);
      chk({tag, "_nreads"}, n_reads - rbase, DEPTH);
      for (int k = 0; k < 4 * DEPTH && k < n; k++)
         chk($sformatf("%s_tx%0d", tag, k), 32'(tx_log[tbase + k]),
             (words[k / 4] >> (24 - 8 * (k % 4))) & 32'hFF);
      chk({tag, "_count"}, 32'(O_WORD_COUNT), DEPTH);
      chk({tag, "_busy"},  32'(O_BUSY), 0);
   endtask

   initial begin
      logic [7:0]  b[$];
      logic [31:0] words[$];
      logic [31:0] full_words[$];
      logic [31:0] v;
      int          acc, wbase, rbase, tbase;
      bit          done_seen;

      RESET = 1'b1; I_START = 1'b0; I_DUMP = 1'b0;
      I_RX_BYTE = '0; I_RX_VALID = 1'b0; I_TX_READY = 1'b0;
      repeat (3) tick();
      check_idle_zero("reset");
      RESET = 1'b0;
      tick();

      // Load with terminator in the third word.
      b = '{8'h20, 8'h21, 8'h00, 8'h0F, 8'hF8, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      wbase = wr_data_log.size();
      pulse_start();
      feed(b, 400, 1'b0, acc, done_seen);
      load_model(b, words);
      check_load("load3", words, wbase, acc, done_seen);

      // Full load of DEPTH random non-halt words, followed by surplus bytes.
      b = {};
      for (int w = 0; w < DEPTH; w++) begin
         v = $urandom;
         if (v == HALT) v = 32'h0;
         push_word(b, v);
      end
      push_word(b, 32'h1122_3344);
      wbase = wr_data_log.size();
      pulse_start();
      feed(b, 2000, 1'b0, acc, done_seen);
      load_model(b, full_words);
      check_load("loadfull", full_words, wbase, acc, done_seen);
      chk("loadfull_rxrdy_idle", 32'(O_RX_READY), 0);

      // Dump the random contents back out.
      tbase = tx_log.size(); rbase = n_reads;
      pulse_dump();
      drain(4000, done_seen);
      check_dump("dumprand", full_words, tbase, rbase, done_seen);

      // Memory holds 0x12345678 at 0 and zero elsewhere, then dump it.
      b = {};
      push_word(b, 32'h1234_5678);
      for (int w = 1; w < DEPTH; w++) push_word(b, 32'h0);
      wbase = wr_data_log.size();
      pulse_start();
      feed(b, 2000, 1'b0, acc, done_seen);
      load_model(b, words);
      check_load("loadpat", words, wbase, acc, done_seen);
      tbase = tx_log.size(); rbase = n_reads;
      pulse_dump();
      drain(4000, done_seen);
      check_dump("dumppat", words, tbase, rbase, done_seen);

      // START and DUMP together select load; DUMP during RX is ignored.
      wbase = wr_data_log.size(); rbase = n_reads;
      tick(); I_START = 1'b1; I_DUMP = 1'b1;
      tick(); I_START = 1'b0; I_DUMP = 1'b0;
      chk("contend_rxrdy", 32'(O_RX_READY), 1);
      chk("contend_noread", 32'(O_MEMREAD), 0);
      I_DUMP = 1'b1;
      tick(); I_DUMP = 1'b0;
      chk("dumpinrx_rxrdy", 32'(O_RX_READY), 1);
      b = {};
      push_word(b, $urandom & 32'h7FFF_FFFF);
      push_word(b, HALT);
      feed(b, 400, 1'b0, acc, done_seen);
      load_model(b, words);
      check_load("contend", words, wbase, acc, done_seen);
      chk("contend_reads", n_reads - rbase, 0);

      // Reset after two bytes of the second word: abort, no partial write.
      wbase = wr_data_log.size();
      b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66};
      pulse_start();
      feed(b, 400, 1'b1, acc, done_seen);
      tick();
      chk("midrst_pre_writes", wr_data_log.size() - wbase, 1);
      chk("midrst_pre_busy", 32'(O_BUSY), 1);
      RESET = 1'b1;
      #1;
      check_idle_zero("midrst");
      repeat (3) tick();
      chk("midrst_writes", wr_data_log.size() - wbase, 1);
      RESET = 1'b0;
      tick();
      wbase = wr_data_log.size();
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      pulse_start();
      feed(b, 400, 1'b0, acc, done_seen);
      load_model(b, words);
      check_load("afterrst", words, wbase, acc, done_seen);

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
